note_sequencer: RTL

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/note_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/note_sequencer.sv
// Step-table note sequencer: plays up to 16 {note, beats} steps with a fixed
// silent gap between steps, optionally looping, and drives a tone generator.
module note_sequencer #(
  parameter int BEAT_TICKS = 12_500_000,
  parameter int GAP_TICKS  = 500_000
) (
  input  logic       inclk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [2:0] wr_note,
  input  logic [2:0] wr_beats,
  output logic [2:0] note_sel,
  output logic       tone_en,
  output logic       busy,
  output logic       done,
  output logic [3:0] step_idx
);

  localparam int MAX_TICKS = (BEAT_TICKS > GAP_TICKS) ? BEAT_TICKS : GAP_TICKS;
  localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BEAT_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP, S_DONE} state_t;

  typedef struct packed {
    logic [2:0] note;
    logic [2:0] beats;
  } step_t;

  step_t            tbl [16];
  state_t           state, state_n;
  logic [2:0]       note_n;
  logic             tone_n, busy_n, done_n;
  logic [3:0]       idx_n;
  logic [2:0]       beats_left, beats_n;
  logic [CNT_W-1:0] tick_cnt, tick_n;

  logic [3:0] next_idx;
  logic [3:0] load_idx;
  logic       load;
  logic       song_end;
  step_t      ld;

  always_ff @(posedge inclk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) tbl[i] <= '0;
    end else if (wr_en) begin
      tbl[wr_addr] <= {wr_note, wr_beats};
    end
  end

  always_ff @(posedge inclk) begin
    if (rst) begin
      state      <= S_IDLE;
      note_sel   <= '0;
      tone_en    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      step_idx   <= '0;
      beats_left <= '0;
      tick_cnt   <= '0;
    end else begin
      state      <= state_n;
      note_sel   <= note_n;
      tone_en    <= tone_n;
      busy       <= busy_n;
      done       <= done_n;
      step_idx   <= idx_n;
      beats_left <= beats_n;
      tick_cnt   <= tick_n;
    end
  end

  always_comb begin
    state_n  = state;
    note_n   = note_sel;
    tone_n   = tone_en;
    busy_n   = busy;
    done_n   = 1'b0;
    idx_n    = step_idx;
    beats_n  = beats_left;
    tick_n   = tick_cnt;
    next_idx = step_idx + 4'd1;
    load     = 1'b0;
    load_idx = '0;
    song_end = 1'b0;
    ld       = '0;

    if (stop) begin
      state_n = S_IDLE;
      note_n  = '0;
      tone_n  = 1'b0;
      busy_n  = 1'b0;
      idx_n   = '0;
      beats_n = '0;
      tick_n  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          note_n  = '0;
          tone_n  = 1'b0;
          busy_n  = 1'b0;
          idx_n   = '0;
          beats_n = '0;
          tick_n  = '0;
          if (start) begin
            load     = 1'b1;
            load_idx = '0;
          end
        end
        S_PLAY: begin
          // Beats are counted down in whole-beat units so no multiplier is needed.
          if (tick_cnt == BEAT_LAST) begin
            tick_n = '0;
            if (beats_left <= 3'd1) begin
              state_n = S_GAP;
              tone_n  = 1'b0;
              beats_n = '0;
            end else begin
              beats_n = beats_left - 3'd1;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (tick_cnt == GAP_LAST) begin
            tick_n = '0;
            if (step_idx == 4'd15 || tbl[next_idx].beats == 3'd0) begin
              song_end = 1'b1;
            end else begin
              load     = 1'b1;
              load_idx = next_idx;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        S_DONE: begin
          state_n = S_IDLE;
          note_n  = '0;
          tone_n  = 1'b0;
          busy_n  = 1'b0;
          idx_n   = '0;
          beats_n = '0;
          tick_n  = '0;
        end
        default: state_n = S_IDLE;
      endcase

      if (song_end) begin
        if (loop_en) begin
          load     = 1'b1;
          load_idx = '0;
        end else begin
          state_n = S_DONE;
          tone_n  = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end

      // Entering a step latches its note and length; a zero-length step 0
      // (including at a loop wrap) ends the song instead of playing.
      if (load) begin
        ld      = tbl[load_idx];
        idx_n   = load_idx;
        note_n  = ld.note;
        beats_n = ld.beats;
        tick_n  = '0;
        if (ld.beats != 3'd0) begin
          state_n = S_PLAY;
          tone_n  = 1'b1;
          busy_n  = 1'b1;
        end else begin
          state_n = S_DONE;
          tone_n  = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
    end
  end

endmodule
